fetch_prefetch: RTL
===================

# fetch_prefetch

Parametrised instruction-fetch front end with a decoupled prefetch queue between instruction memory and IF/ID. Issues sequential word fetches over a request/grant memory port with in-order, variable-latency responses. Buffers up to FIFO_DEPTH instructions with their PCs and hands them to decode over a valid/ready handshake. A redirect discards queued and in-flight fetches and restarts at a new PC.

## Interface
- ADDR_W, 32: PC and memory address width.
- INSTR_W, 32: instruction width.
- FIFO_DEPTH, 4: queue entries, power of two and ≥2; also the maximum number of outstanding memory requests.
- RESET_PC, 32'h0000_0000: fetch address after reset.
- clk, in, 1: single clock; all state on rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- redirect_valid, in, 1: branch/jump/flush redirect.
- redirect_pc, in, ADDR_W: new fetch address; bits [1:0] are ignored and treated as 0.
- imem_req, out, 1: fetch request.
- imem_addr, out, ADDR_W: word-aligned request address.
- imem_gnt, in, 1: request accepted this cycle; only meaningful while imem_req=1.
- imem_rvalid, in, 1: response valid; responses return in request order.
- imem_rdata, in, INSTR_W: response instruction.
- if_valid, out, 1: instruction available to IF/ID.
- if_ready, in, 1: IF/ID accepts.
- if_instr, out, INSTR_W: head instruction.
- if_pc, out, ADDR_W: PC of head instruction.

## Operation
- State:
  - fetch_pc.
  - Queue pointers: alloc_ptr, fill_ptr, rd_ptr, each log2(FIFO_DEPTH)+1 bits with a wrap bit.
  - drop_cnt, 0..FIFO_DEPTH.
- Derived quantities:
  - occ = alloc_ptr − rd_ptr.
  - Entry is filled when it lies between rd_ptr and fill_ptr.
- Issue:
  - imem_req = (occ + drop_cnt < FIFO_DEPTH) & ~redirect_valid.
  - imem_addr = fetch_pc.
  - Request may be withdrawn only by a redirect; otherwise req and addr hold stable until granted.
- Grant:
  - Write fetch_pc into pc slot[alloc_ptr] and advance alloc_ptr.
  - fetch_pc += 4, wrapping modulo 2^ADDR_W.
- Response when drop_cnt>0: discard it and decrement drop_cnt.
- Response when drop_cnt=0: write imem_rdata into slot[fill_ptr] and advance fill_ptr.
- Pop:
  - if_valid = (fill_ptr ≠ rd_ptr) & ~redirect_valid.
  - if_instr and if_pc come from slot[rd_ptr].
  - if_valid & if_ready advances rd_ptr.
- Redirect (highest priority):
  - fetch_pc ← {redirect_pc[ADDR_W-1:2], 2'b00}.
  - alloc_ptr, fill_ptr and rd_ptr all ← 0.
  - drop_cnt ← drop_cnt + (alloc_ptr − fill_ptr) − (imem_rvalid ? 1 : 0).
  - A same-cycle response is consumed against the old stream.
  - No grant or pop can occur in the redirect cycle, because imem_req and if_valid are gated.
- Boundaries:
  - Queue full means occ = FIFO_DEPTH; imem_req then stays low and no overflow is possible.
  - Queue empty means if_valid=0.
  - Simultaneous grant, response and pop in one cycle are all legal and independent.
  - A response with no outstanding request is a protocol error; assert it in simulation.

## Timing
- During reset and asynchronously on rst_n low:
  - fetch_pc=RESET_PC, all pointers=0, drop_cnt=0.
  - if_valid=0, imem_req=0.
- Reset can assert mid-operation; it clears all in-flight state immediately.
- First cycle after reset release: imem_req=1, imem_addr=RESET_PC.
- imem_rvalid in cycle N gives if_valid=1 in cycle N+1, since queue storage is registered.
- With single-cycle memory and if_ready=1, throughput is one instruction per cycle after a 2-cycle startup.
- Redirect in cycle T gives imem_req=1 with imem_addr=redirect_pc in cycle T+1, if drop_cnt permits.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds 32-bit outputs perf_fetch_cnt (count of pop handshakes) and perf_drop_cnt (count of discarded responses).
  - Both reset to 0 and wrap on overflow.
- FETCH_PERF_CNT_EN undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- pc_defnitions package holds:
  - INSTR_BYTES=4.
  - The default reset PC constant.
  - A fetch_entry_t typedef {pc, instr}.
- Sub-module fetch_queue contains:
  - Entry storage and the three pointers.
  - occ and filled flags.
  - Synchronous clear.
- fetch_prefetch contains fetch_pc, issue logic, drop_cnt and redirect logic.

## Test plan
- Reset release with mem latency 1 and if_ready=1 -> if_pc sequence 0x0, 0x4, 0x8… one per cycle from cycle 3.
- if_ready=0 for 10 cycles, FIFO_DEPTH=4 -> exactly 4 grants, then imem_req=0; releasing ready drains 0x0..0xC in order with no loss.
- Mem latency 3 with 3 requests in flight, then redirect to 0x103 -> 3 responses discarded, first if_pc=0x100, perf_drop_cnt=3.
- Redirect in the same cycle as imem_rvalid and an if_valid head -> no handshake that cycle, drop_cnt = in-flight−1, next if_pc = redirect target.
- Random gnt/rvalid stalls plus random redirects over 10k cycles -> decoded PC stream matches reference model, no response ever fills a post-redirect entry.
- rst_n pulsed low mid-burst -> all outputs return to reset values the same cycle, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_pkg.sv
// Shared fetch-front-end definitions: instruction size, default reset PC
// and the {pc, instr} queue entry type.
package pc_defnitions;

  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: PC slots are allocated at grant time, instruction slots are
// filled in order as responses return, and entries pop from the head.
module fetch_queue #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  localparam int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               alloc_en,
  input  logic [ADDR_W-1:0]  alloc_pc,
  input  logic               fill_en,
  input  logic [INSTR_W-1:0] fill_instr,
  input  logic               pop_en,
  output logic [PTR_W-1:0]   occ,
  output logic [PTR_W-1:0]   pending,
  output logic               filled,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  localparam int IDX_W = PTR_W - 1;

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]   alloc_ptr;
  logic [PTR_W-1:0]   fill_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // Storage needs no reset; pointers alone decide which slots are meaningful.
  always_ff @(posedge clk) begin
    if (alloc_en) pc_mem[alloc_ptr[IDX_W-1:0]] <= alloc_pc;
    if (fill_en)  instr_mem[fill_ptr[IDX_W-1:0]] <= fill_instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
    end else if (clear) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
    end else begin
      if (alloc_en) alloc_ptr <= alloc_ptr + 1'b1;
      if (fill_en)  fill_ptr  <= fill_ptr + 1'b1;
      if (pop_en)   rd_ptr    <= rd_ptr + 1'b1;
    end
  end

  assign occ        = alloc_ptr - rd_ptr;
  assign pending    = alloc_ptr - fill_ptr;
  assign filled     = (fill_ptr != rd_ptr);
  assign head_pc    = pc_mem[rd_ptr[IDX_W-1:0]];
  assign head_instr = instr_mem[rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end with a decoupled prefetch queue and redirect flush.
// Optional FETCH_PERF_CNT_EN adds pop and discarded-response counters.
module fetch_prefetch
  import pc_defnitions::*;
#(
  parameter int ADDR_W     = 32,
  parameter int INSTR_W    = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_drop_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  drop_cnt;
  logic [PTR_W-1:0]  occ;
  logic [PTR_W-1:0]  pending;
  logic [PTR_W:0]    budget;
  logic              filled;
  logic              grant;
  logic              pop;
  logic              drop_resp;
  logic              fill_resp;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Live entries plus responses still owed to a flushed stream bound new requests.
  assign budget    = {1'b0, occ} + {1'b0, drop_cnt};
  assign imem_req  = rst_n & ~redirect_valid & (budget < (PTR_W+1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc;
  assign grant     = imem_req & imem_gnt;
  assign if_valid  = filled & ~redirect_valid;
  assign pop       = if_valid & if_ready;
  assign drop_resp = imem_rvalid & (drop_cnt != '0);
  assign fill_resp = imem_rvalid & (drop_cnt == '0) & ~redirect_valid;

  fetch_queue #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (FIFO_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (redirect_valid),
    .alloc_en   (grant),
    .alloc_pc   (fetch_pc),
    .fill_en    (fill_resp),
    .fill_instr (imem_rdata),
    .pop_en     (pop),
    .occ        (occ),
    .pending    (pending),
    .filled     (filled),
    .head_pc    (if_pc),
    .head_instr (if_instr)
  );

  // On redirect every in-flight request becomes a drop, less any response landing now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      drop_cnt <= drop_cnt + pending - PTR_W'(imem_rvalid);
    end else begin
      if (grant)     fetch_pc <= fetch_pc + ADDR_W'(INSTR_BYTES);
      if (drop_resp) drop_cnt <= drop_cnt - 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(pop);
      perf_drop_cnt  <= perf_drop_cnt + 32'(imem_rvalid & ((drop_cnt != '0) | redirect_valid));
    end
  end
`endif

  resp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> ((drop_cnt != '0) || (pending != '0)));

endmodule
